if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage_if.sv | 37 +++
 rtl/if_id_stage.sv | 77 +++++++
 tb/tb_if_id_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/if_id_stage_if.sv
// IF/ID stage bundle: redirect/hold control, imem handshake and IF/ID pipeline outputs.
// Latency: none (wires only); all timing lives in the stage that uses the slave modport.
// Backpressure: hold_IFID from the hazard unit and imem_ready from instruction memory.
// Ports (slave view):
//   in : hold_IFID, BranchTaken_EX, BranchTarget_EX[31:0], Jump_ID, JumpTarget_ID[31:0],
//        imem_ready, Instruction_IF[31:0]
//   out: PC_IF[31:0], Instruction_ID[31:0], PC_plus4_ID[31:0], valid_ID,
//        stall_cnt[15:0], bubble_cnt[15:0]
interface if_id_stage_if;
  logic        hold_IFID;
  logic        BranchTaken_EX;
  logic [31:0] BranchTarget_EX;
  logic        Jump_ID;
  logic [31:0] JumpTarget_ID;
  logic        imem_ready;
  logic [31:0] Instruction_IF;
  logic [31:0] PC_IF;
  logic [31:0] Instruction_ID;
  logic [31:0] PC_plus4_ID;
  logic        valid_ID;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  // Driven by the surrounding pipeline / memory model.
  modport master (
    output hold_IFID, BranchTaken_EX, BranchTarget_EX, Jump_ID, JumpTarget_ID,
           imem_ready, Instruction_IF,
    input  PC_IF, Instruction_ID, PC_plus4_ID, valid_ID, stall_cnt, bubble_cnt
  );

  // Used by the fetch stage itself.
  modport slave (
    input  hold_IFID, BranchTaken_EX, BranchTarget_EX, Jump_ID, JumpTarget_ID,
           imem_ready, Instruction_IF,
    output PC_IF, Instruction_ID, PC_plus4_ID, valid_ID, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch PC register plus IF/ID pipeline latch with redirect, stall and imem-wait handling.
// Latency: one clock from Instruction_IF at PC_IF to Instruction_ID; all outputs registered.
// Backpressure: hold_IFID freezes PC and IF/ID; imem_ready=0 inserts a bubble and refetches.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous active-high reset
//   bus   - if_id_stage_if.slave (control inputs, imem word in, PC/IF-ID/counters out)
module if_id_stage (
  input  logic           clk,
  input  logic           reset,
  if_id_stage_if.slave   bus
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;

  logic [31:0] w_pc_plus4;
  logic [15:0] w_stall_next;
  logic [15:0] w_bubble_next;

  // 32-bit add wraps naturally at 0xFFFFFFFC -> 0x00000000.
  assign w_pc_plus4    = r_pc + 32'd4;
  // Counters stick at all-ones instead of wrapping.
  assign w_stall_next  = (r_stall_cnt  == 16'hFFFF) ? r_stall_cnt  : r_stall_cnt  + 16'd1;
  assign w_bubble_next = (r_bubble_cnt == 16'hFFFF) ? r_bubble_cnt : r_bubble_cnt + 16'd1;

  // Priority: reset > branch > jump > hold > imem wait > normal fetch.
  // A cleared IF/ID word (0x00000000) is a nop for decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= 32'h0000_0000;
      r_instr      <= 32'h0000_0000;
      r_pc4        <= 32'h0000_0000;
      r_valid      <= 1'b0;
      r_stall_cnt  <= 16'h0000;
      r_bubble_cnt <= 16'h0000;
    end else if (bus.BranchTaken_EX) begin
      r_pc         <= {bus.BranchTarget_EX[31:2], 2'b00};
      r_instr      <= 32'h0000_0000;
      r_pc4        <= 32'h0000_0000;
      r_valid      <= 1'b0;
      r_bubble_cnt <= w_bubble_next;
    end else if (bus.Jump_ID) begin
      r_pc         <= {bus.JumpTarget_ID[31:2], 2'b00};
      r_instr      <= 32'h0000_0000;
      r_pc4        <= 32'h0000_0000;
      r_valid      <= 1'b0;
      r_bubble_cnt <= w_bubble_next;
    end else if (bus.hold_IFID) begin
      // Everything frozen; imem_ready is irrelevant while held.
      r_stall_cnt  <= w_stall_next;
    end else if (!bus.imem_ready) begin
      // Keep PC so the same address is refetched once memory is ready.
      r_instr      <= 32'h0000_0000;
      r_pc4        <= 32'h0000_0000;
      r_valid      <= 1'b0;
      r_bubble_cnt <= w_bubble_next;
    end else begin
      r_pc         <= w_pc_plus4;
      r_instr      <= bus.Instruction_IF;
      r_pc4        <= w_pc_plus4;
      r_valid      <= 1'b1;
    end
  end

  assign bus.PC_IF          = r_pc;
  assign bus.Instruction_ID = r_instr;
  assign bus.PC_plus4_ID    = r_pc4;
  assign bus.valid_ID       = r_valid;
  assign bus.stall_cnt      = r_stall_cnt;
  assign bus.bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with an expected-value queue and a separate monitor.
// Inputs change on the falling edge; outputs are compared 1 time unit after the rising edge.
module tb_if_id_stage;

  logic clk;
  logic reset;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: two fixed words at 0 and 4, elsewhere 0xC0DE_<addr[15:0]>.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: imem_word = 32'h2008_0001;
      32'h0000_0004: imem_word = 32'h2009_0002;
      default:       imem_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign bus.Instruction_IF = imem_word(bus.PC_IF);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        v;
    logic [15:0] sc;
    logic [15:0] bc;
    bit          chk;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: one expected entry per clock, applied to the state after that edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        n_checks++;
        if (bus.PC_IF !== e.pc || bus.Instruction_ID !== e.instr ||
            bus.PC_plus4_ID !== e.pc4 || bus.valid_ID !== e.v ||
            bus.stall_cnt !== e.sc || bus.bubble_cnt !== e.bc) begin
          n_fail++;
          $display("FAIL %s: got pc=%h ins=%h pc4=%h v=%b sc=%h bc=%h want pc=%h ins=%h pc4=%h v=%b sc=%h bc=%h",
                   e.name, bus.PC_IF, bus.Instruction_ID, bus.PC_plus4_ID, bus.valid_ID,
                   bus.stall_cnt, bus.bubble_cnt, e.pc, e.instr, e.pc4, e.v, e.sc, e.bc);
        end
      end
    end
  end

  task automatic drv(input logic rst, input logic hold, input logic br, input logic [31:0] bt,
                     input logic jmp, input logic [31:0] jt, input logic rdy,
                     input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4,
                     input logic v, input logic [15:0] sc, input logic [15:0] bc,
                     input bit chk, input string name);
    exp_t e;
    @(negedge clk);
    reset               = rst;
    bus.hold_IFID       = hold;
    bus.BranchTaken_EX  = br;
    bus.BranchTarget_EX = bt;
    bus.Jump_ID         = jmp;
    bus.JumpTarget_ID   = jt;
    bus.imem_ready      = rdy;
    e.pc = pc; e.instr = instr; e.pc4 = pc4; e.v = v; e.sc = sc; e.bc = bc;
    e.chk = chk; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    bus.hold_IFID = 1'b0; bus.BranchTaken_EX = 1'b0; bus.BranchTarget_EX = '0;
    bus.Jump_ID = 1'b0; bus.JumpTarget_ID = '0; bus.imem_ready = 1'b1;

    //   rst hold br  bt            jmp jt            rdy  pc            instr         pc4           v  sc        bc
    drv(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd0, 16'd0, 1, "reset");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1, 16'd0, 16'd0, 1, "fetch0");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 32'h2009_0002, 32'h0000_0008, 1, 16'd0, 16'd0, 1, "fetch1");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_000C, 32'hC0DE_0008, 32'h0000_000C, 1, 16'd0, 16'd0, 1, "fetch2");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0010, 32'hC0DE_000C, 32'h0000_0010, 1, 16'd0, 16'd0, 1, "fetch3");
    // hold 3 cycles at 0x10; imem_ready low in the middle one must be ignored
    drv(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0010, 32'hC0DE_000C, 32'h0000_0010, 1, 16'd1, 16'd0, 1, "hold1");
    drv(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0010, 32'hC0DE_000C, 32'h0000_0010, 1, 16'd2, 16'd0, 1, "hold2");
    drv(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0010, 32'hC0DE_000C, 32'h0000_0010, 1, 16'd3, 16'd0, 1, "hold3");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0014, 32'hC0DE_0010, 32'h0000_0014, 1, 16'd3, 16'd0, 1, "release");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0018, 32'hC0DE_0014, 32'h0000_0018, 1, 16'd3, 16'd0, 1, "fetch14");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_001C, 32'hC0DE_0018, 32'h0000_001C, 1, 16'd3, 16'd0, 1, "fetch18");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0020, 32'hC0DE_001C, 32'h0000_0020, 1, 16'd3, 16'd0, 1, "fetch1c");
    // imem not ready 2 cycles at 0x20
    drv(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd1, 1, "imwait1");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd2, 1, "imwait2");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0024, 32'hC0DE_0020, 32'h0000_0024, 1, 16'd3, 16'd2, 1, "imready");
    // jump beats hold, target low bits dropped
    drv(0, 1, 0, 32'h0,        1, 32'h207,      1, 32'h0000_0204, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd3, 1, "jump_hold");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0208, 32'hC0DE_0204, 32'h0000_0208, 1, 16'd3, 16'd3, 1, "fetch204");
    // branch beats jump and hold
    drv(0, 1, 1, 32'h103,      1, 32'h500,      1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd4, 1, "br_jmp_hold");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0104, 32'hC0DE_0100, 32'h0000_0104, 1, 16'd3, 16'd4, 1, "fetch100");
    // PC wrap
    drv(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,       1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd5, 1, "br_top");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 32'hC0DE_FFFC, 32'h0000_0000, 1, 16'd3, 16'd5, 1, "wrap");
    // stall counter saturation
    drv(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd0, 16'd0, 1, "reset2");
    for (int i = 1; i <= 65535; i++)
      drv(0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0, 16'(i), 16'd0,
          (i == 1 || i == 65535), "hold_preload");
    drv(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'hFFFF, 16'd0, 1, "stall_sat");
    // fetch one word, then reset during a hold/redirect
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1, 16'hFFFF, 16'd0, 1, "fetch_pre");
    drv(1, 1, 1, 32'h40,       1, 32'h80,       1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd0, 16'd0, 1, "reset_hold");
    drv(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1, 16'd0, 16'd0, 1, "first_fetch");

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
